// File: rtl/serial_logic16.sv
// Bit-serial bitwise logic unit: evaluates AND/OR/NAND/XOR one bit per clock,
// LSB first, behind valid/ready handshakes on both operand and result sides.
module serial_logic16 #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             bit_f;
    logic             last;

    function automatic logic logic_bit(input logic [1:0] opc, input logic x, input logic z);
        logic r;
        case (opc)
            2'b00:   r = x & z;
            2'b01:   r = x | z;
            2'b10:   r = ~(x & z);
            default: r = x ^ z;
        endcase
        return r;
    endfunction

    assign bit_f  = logic_bit(op_q, a_sh[0], b_sh[0]);
    assign last   = (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_nx = {bit_f, {(WIDTH-1){1'b0}}} | (res_sh >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            y_q    <= '0;
            op_q   <= 2'b00;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            op_q   <= op;
            res_sh <= '0;
            cnt    <= '0;
        end else if (state == BUSY && !abort) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            cnt    <= cnt + CW'(1);
            if (last) begin
                y_q <= res_nx;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_serial_logic16.sv
// Directed and randomized bench for serial_logic16 with hand-computed results.
module tb_serial_logic16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         in_ready;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] y;

    int vectors = 0;
    int miscompares = 0;

    serial_logic16 #(.WIDTH(W), .CW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .abort(abort), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for a single accepting edge, then scramble the inputs.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~ta; b = ~tb; op = ~top;
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = 1;
        bcnt  = 0;
        while (!out_valid && edges < 60) begin
            if (busy) bcnt++;
            tick();
            edges++;
        end
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        case (o)
            2'b00:   return x & z;
            2'b01:   return x | z;
            2'b10:   return ~(x & z);
            default: return x ^ z;
        endcase
    endfunction

    task automatic test_reset();
        #2;
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100 || y !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held: rdy/busy/vld=%b y=%h want 100 y=0000", {in_ready, busy, out_valid}, y);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tick();
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100 || y !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_release: rdy/busy/vld=%b y=%h want 100 y=0000", {in_ready, busy, out_valid}, y);
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic [1:0] top, input logic [W-1:0] exp);
        int edges, bcnt;
        start_op(ta, tb, top);
        wait_done(edges, bcnt);
        vectors++;
        if (edges !== 17 || bcnt !== 16) begin
            miscompares++;
            $display("FAIL %s_latency: edges=%0d busy=%0d want 17/16", name, edges, bcnt);
        end
        vectors++;
        if (y !== exp) begin
            miscompares++;
            $display("FAIL %s_result: y=%h want %h", name, y, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== exp) begin
            miscompares++;
            $display("FAIL %s_ack: vld=%b rdy=%b y=%h want 0/1 y=%h", name, out_valid, in_ready, y, exp);
        end
    endtask

    task automatic test_ops();
        run_and_check("and", 16'hF0F0, 16'hFF00, 2'b00, 16'hF000);
        run_and_check("or",  16'h1234, 16'h0FF0, 2'b01, 16'h1FF4);
        run_and_check("nand", 16'h1234, 16'h0FF0, 2'b10, 16'hFDCF);
        run_and_check("xor", 16'h1234, 16'h0FF0, 2'b11, 16'h1DC4);
    endtask

    task automatic test_back_to_back();
        int edges, bcnt;
        int bad = 0;
        start_op(16'hAAAA, 16'h5555, 2'b01);
        wait_done(edges, bcnt);
        a = 16'h00FF; b = 16'h0F0F; op = 2'b11; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 16'hFFFF) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: %0d bad cycles, y=%h want FFFF held", bad, y);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: rdy=%b vld=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_accept: busy=%b rdy=%b want 1/0", busy, in_ready);
        end
        wait_done(edges, bcnt);
        vectors++;
        if (y !== 16'h0FF0 || edges !== 17) begin
            miscompares++;
            $display("FAIL stall_next: y=%h edges=%0d want 0FF0/17", y, edges);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen = 0;
        start_op(16'hFFFF, 16'h0000, 2'b01);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || y !== 16'h0FF0) begin
            miscompares++;
            $display("FAIL abort_idle: rdy=%b busy=%b vld=%b y=%h want 1/0/0 y=0FF0", in_ready, busy, out_valid, y);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0 || y !== 16'h0FF0) begin
            miscompares++;
            $display("FAIL abort_quiet: out_valid seen %0d times, y=%h want 0 / 0FF0", seen, y);
        end
        abort = 1'b1;
        start_op(16'hFFFF, 16'hAAAA, 2'b00);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_with_valid: busy=%b want 1", busy);
        end
        begin
            int edges, bcnt;
            wait_done(edges, bcnt);
            vectors++;
            if (y !== 16'hAAAA || edges !== 17) begin
                miscompares++;
                $display("FAIL abort_fresh: y=%h edges=%0d want AAAA/17", y, edges);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start_op(16'h1111, 16'h2222, 2'b01);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100 || y !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset: rdy/busy/vld=%b y=%h want 100 y=0000", {in_ready, busy, out_valid}, y);
        end
        tick();
        rst = 1'b0;
        tick();
        run_and_check("post_reset", 16'h5A5A, 16'h00FF, 2'b10, 16'hFFA5);
    endtask

    task automatic test_random();
        int bad_res = 0, bad_hold = 0, bad_drop = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb, exp, held;
            logic [1:0]   rop;
            int edges, bcnt;
            ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom_range(0, 3));
            exp = ref_fn(rop, ra, rb);
            repeat ($urandom_range(0, 2)) tick();
            start_op(ra, rb, rop);
            wait_done(edges, bcnt);
            if (y !== exp || edges !== 17) bad_res++;
            held = y;
            repeat ($urandom_range(0, 4)) tick();
            if (out_valid !== 1'b1 || y !== held) bad_hold++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (out_valid !== 1'b0) bad_drop++;
        end
        vectors++;
        if (bad_res != 0) begin
            miscompares++;
            $display("FAIL random_result: %0d of 1000 wrong, want 0", bad_res);
        end
        vectors++;
        if (bad_hold != 0) begin
            miscompares++;
            $display("FAIL random_stall: %0d stalls lost result, want 0", bad_hold);
        end
        vectors++;
        if (bad_drop != 0) begin
            miscompares++;
            $display("FAIL random_ack: %0d results duplicated, want 0", bad_drop);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
